dequantizer: RTL and testbench

Streaming inverse of the 4-bit, 10-level quantizer: accepts quantized level codes over a valid/ready handshake and emits the IEEE-754 single-precision reconstruction value for each code. It sits on the decode/readback path of the sparse HDC datapath, after the level LUT and before any float consumer. It tags the last element of each hypervector and counts illegal codes. One registered output stage plus a one-entry skid buffer give full throughput with a registered `in_ready`.

---
 rtl/hdc_quant_pkg.sv | 37 +++
 rtl/skid_buf.sv | 70 +++++++
 rtl/dequantizer.sv | 77 +++++++
 tb/tb_dequantizer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdc_quant_pkg.sv
// Shared constants for the 4-bit, 10-level HDC quantizer and its inverse.
// Encoder thresholds and decoder reconstruction values live side by side.
package hdc_quant_pkg;

    localparam int unsigned LEVELS  = 10;
    localparam int unsigned LEVEL_W = 4;

    // Inner bins reconstruct to their midpoint; the outer bins saturate to +/-1.0.
    localparam logic [31:0] LEVEL_FP [LEVELS] = '{
        32'hBF800000, 32'hBF471C72, 32'hBF0E38E4, 32'hBEAAAAAB, 32'hBDE38E39,
        32'h3DE38E39, 32'h3EAAAAAB, 32'h3F0E38E4, 32'h3F471C72, 32'h3F800000
    };

    // Bin edges used by the encoder: -8/9, -2/3, -4/9, -2/9, 0, 2/9, 4/9, 2/3, 8/9.
    localparam logic [31:0] LEVEL_THR [LEVELS-1] = '{
        32'hBF638E39, 32'hBF2AAAAB, 32'hBEE38E39, 32'hBE638E39, 32'h00000000,
        32'h3E638E39, 32'h3EE38E39, 32'h3F2AAAAB, 32'h3F638E39
    };

    typedef struct packed {
        logic [31:0] value;
        logic        err;
    } level_fp_t;

    function automatic level_fp_t level_to_fp(input logic [LEVEL_W-1:0] level);
        level_fp_t r;
        if (level < LEVEL_W'(LEVELS)) begin
            r.value = LEVEL_FP[level];
            r.err   = 1'b0;
        end else begin
            r.value = '0;
            r.err   = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/skid_buf.sv
// Registered output stage O plus a one-entry skid register S.
// in_ready is derived from a register so it never depends on out_ready.
module skid_buf #(
    parameter int unsigned WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             o_valid_q, o_valid_d;
    logic [WIDTH-1:0] o_data_q, o_data_d;
    logic             s_valid_q, s_valid_d;
    logic [WIDTH-1:0] s_data_q, s_data_d;
    logic             ready_q;
    logic             accept, drain;

    assign in_ready  = ready_q & en & ~rst;
    assign accept    = in_valid & in_ready;
    assign drain     = o_valid_q & out_ready;
    assign out_valid = o_valid_q;
    assign out_data  = o_data_q;

    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        if (drain) begin
            o_valid_d = 1'b0;
        end
        // S full implies in_ready is low, so refill from S and accept never coincide.
        if (drain && s_valid_q) begin
            o_valid_d = 1'b1;
            o_data_d  = s_data_q;
            s_valid_d = 1'b0;
        end else if (accept) begin
            if (!o_valid_q || drain) begin
                o_valid_d = 1'b1;
                o_data_d  = in_data;
            end else begin
                s_valid_d = 1'b1;
                s_data_d  = in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
            ready_q   <= 1'b1;
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
            ready_q   <= ~s_valid_d;
        end
    end

endmodule

// File: rtl/dequantizer.sv
// Streaming level-code to IEEE-754 reconstruction with vector-end tagging
// and a saturating illegal-code counter.
module dequantizer
    import hdc_quant_pkg::*;
#(
    parameter int unsigned VEC_LEN = 1024,
    parameter int unsigned ERR_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LEVEL_W-1:0] in_level,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_value,
    output logic               out_last,
    output logic               out_err,
    output logic [ERR_W-1:0]   err_count
);

    localparam int unsigned    IDX_W    = $clog2(VEC_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ERR_W-1:0] err_q, err_d;
    level_fp_t        fp;
    logic             accept, last;
    logic [33:0]      in_data, out_data;

    assign fp      = level_to_fp(in_level);
    assign accept  = in_valid & in_ready;
    assign last    = (idx_q == LAST_IDX);
    assign in_data = {fp.value, last, fp.err};

    always_comb begin
        idx_d = idx_q;
        err_d = err_q;
        if (accept) begin
            idx_d = last ? '0 : idx_q + IDX_W'(1);
            if (fp.err && (err_q != '1)) begin
                err_d = err_q + ERR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            err_q <= '0;
        end else begin
            idx_q <= idx_d;
            err_q <= err_d;
        end
    end

    skid_buf #(
        .WIDTH(34)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    assign out_value = out_data[33:2];
    assign out_last  = out_data[1];
    assign out_err   = out_data[0];
    assign err_count = err_q;

endmodule

// File: tb/tb_dequantizer.sv
// Directed bench for dequantizer with short vectors and a narrow error counter.
module tb_dequantizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_level;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_value;
    logic        out_last;
    logic        out_err;
    logic [7:0]  err_count;

    int errors = 0;
    int checks = 0;
    logic [31:0] fp_tab [16];

    always #5 clk = ~clk;

    dequantizer #(
        .VEC_LEN(4),
        .ERR_W  (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_level (in_level),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_value(out_value),
        .out_last (out_last),
        .out_err  (out_err),
        .err_count(err_count)
    );

    task automatic do_reset;
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_level = 4'd0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_level = 4'd0; out_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (out_value !== 32'h0) begin errors++;
            $display("FAIL reset_out_value got=%h want=00000000", out_value); end
        checks++; if (out_last !== 1'b0 || out_err !== 1'b0) begin errors++;
            $display("FAIL reset_flags got last=%b err=%b want 0 0", out_last, out_err); end
        checks++; if (err_count !== 8'h00) begin errors++;
            $display("FAIL reset_err_count got=%h want=00", err_count); end
        checks++; if (in_ready !== 1'b0) begin errors++;
            $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        rst = 1'b0; #1;
        checks++; if (in_ready !== 1'b1) begin errors++;
            $display("FAIL release_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_levels;
        logic [31:0] exp_v [10] = '{
            32'h3F800000, 32'h3F471C72, 32'h3F0E38E4, 32'h3EAAAAAB, 32'h3DE38E39,
            32'hBDE38E39, 32'hBEAAAAAB, 32'hBF0E38E4, 32'hBF471C72, 32'hBF800000
        };
        do_reset;
        en = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_level = 4'd9;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++;
                $display("FAIL levels_valid[%0d] got=%b want=1", i, out_valid); end
            checks++; if (out_value !== exp_v[i]) begin errors++;
                $display("FAIL levels_value[%0d] got=%h want=%h", i, out_value, exp_v[i]); end
            checks++; if (out_err !== 1'b0) begin errors++;
                $display("FAIL levels_err[%0d] got=%b want=0", i, out_err); end
            checks++; if (out_last !== (i % 4 == 3)) begin errors++;
                $display("FAIL levels_last[%0d] got=%b want=%b", i, out_last, (i % 4 == 3)); end
            if (i < 9) in_level = 4'(8 - i);
            else in_valid = 1'b0;
        end
    endtask

    task automatic test_illegal;
        do_reset;
        en = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_level = 4'd10;
        @(negedge clk);
        checks++; if (out_value !== 32'h0 || out_err !== 1'b1) begin errors++;
            $display("FAIL illegal10 got=%h err=%b want=00000000 err=1", out_value, out_err); end
        checks++; if (err_count !== 8'd1) begin errors++;
            $display("FAIL illegal10_count got=%0d want=1", err_count); end
        in_level = 4'd15;
        @(negedge clk);
        checks++; if (out_value !== 32'h0 || out_err !== 1'b1) begin errors++;
            $display("FAIL illegal15 got=%h err=%b want=00000000 err=1", out_value, out_err); end
        checks++; if (err_count !== 8'd2) begin errors++;
            $display("FAIL illegal15_count got=%0d want=2", err_count); end
        in_level = 4'd9;
        @(negedge clk);
        checks++; if (out_value !== 32'h3F800000 || out_err !== 1'b0) begin errors++;
            $display("FAIL legal_after got=%h err=%b want=3F800000 err=0", out_value, out_err); end
        checks++; if (err_count !== 8'd2) begin errors++;
            $display("FAIL legal_after_count got=%0d want=2", err_count); end
        in_level = 4'd12;
        repeat (300) @(negedge clk);
        checks++; if (err_count !== 8'hFF) begin errors++;
            $display("FAIL burst_saturate got=%h want=FF", err_count); end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0 || err_count !== 8'hFF) begin errors++;
            $display("FAIL idle_hold got valid=%b cnt=%h want 0 FF", out_valid, err_count); end
        in_valid = 1'b1; in_level = 4'd13;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_err !== 1'b1) begin errors++;
            $display("FAIL one_more_beat got valid=%b err=%b want 1 1", out_valid, out_err); end
        checks++; if (err_count !== 8'hFF) begin errors++;
            $display("FAIL one_more_saturate got=%h want=FF", err_count); end
    endtask

    task automatic test_last;
        do_reset;
        en = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_level = 4'd5;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 8) in_valid = 1'b0;
            checks++; if (out_valid !== 1'b1 || out_last !== (i == 3 || i == 7)) begin errors++;
                $display("FAIL last_beat%0d got valid=%b last=%b want 1 %b", i + 1, out_valid,
                         out_last, (i == 3 || i == 7)); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] q [$];
        logic [31:0] held = '0;
        int sent = 0;
        int got = 0;
        int stall_acc = 0;
        do_reset;
        en = 1'b1;
        for (int t = 0; t < 40 && got < 8; t++) begin
            @(negedge clk);
            out_ready = !(t >= 2 && t <= 4);
            if (t == 2) held = out_value;
            if (t == 3 || t == 4) begin
                checks++; if (out_valid !== 1'b1 || out_value !== held) begin errors++;
                    $display("FAIL stall_hold t=%0d got valid=%b val=%h want 1 %h", t, out_valid,
                             out_value, held); end
                checks++; if (in_ready !== 1'b0) begin errors++;
                    $display("FAIL stall_in_ready t=%0d got=%b want=0", t, in_ready); end
            end
            if (t == 6) begin
                checks++; if (in_ready !== 1'b1) begin errors++;
                    $display("FAIL ready_return got=%b want=1", in_ready); end
            end
            if (out_valid && out_ready) begin
                checks++; if (q.size() == 0 || out_value !== q[0]) begin errors++;
                    $display("FAIL order_beat%0d got=%h want=%h", got, out_value,
                             (q.size() == 0) ? 32'hx : q[0]); end
                if (q.size() != 0) void'(q.pop_front());
                got++;
            end
            in_valid = (sent < 8);
            in_level = 4'(sent + 1);
            if (in_valid && in_ready) begin
                q.push_back(fp_tab[sent + 1]);
                sent++;
                if (t >= 2 && t <= 4) stall_acc++;
            end
        end
        in_valid = 1'b0;
        checks++; if (stall_acc != 1) begin errors++;
            $display("FAIL stall_absorb got=%0d want=1", stall_acc); end
        checks++; if (got != 8 || q.size() != 0) begin errors++;
            $display("FAIL drain_count got=%0d left=%0d want 8 0", got, q.size()); end
    endtask

    task automatic test_enable;
        do_reset;
        out_ready = 1'b1;
        @(negedge clk);
        en = 1'b1; in_valid = 1'b1; in_level = 4'd1;
        @(negedge clk);
        checks++; if (out_value !== 32'hBF471C72 || out_last !== 1'b0) begin errors++;
            $display("FAIL en_b0 got=%h last=%b want BF471C72 0", out_value, out_last); end
        in_level = 4'd2;
        @(negedge clk);
        checks++; if (out_value !== 32'hBF0E38E4 || out_last !== 1'b0) begin errors++;
            $display("FAIL en_b1 got=%h last=%b want BF0E38E4 0", out_value, out_last); end
        en = 1'b0; in_level = 4'd3; #1;
        checks++; if (in_ready !== 1'b0) begin errors++;
            $display("FAIL en_low_ready got=%b want=0", in_ready); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++;
                $display("FAIL en_low_cycle%0d got valid=%b ready=%b want 0 0", k, out_valid,
                         in_ready); end
        end
        en = 1'b1;
        @(negedge clk);
        checks++; if (out_value !== 32'hBEAAAAAB || out_last !== 1'b0) begin errors++;
            $display("FAIL en_b2 got=%h last=%b want BEAAAAAB 0", out_value, out_last); end
        in_level = 4'd4;
        @(negedge clk);
        checks++; if (out_value !== 32'hBDE38E39 || out_last !== 1'b1) begin errors++;
            $display("FAIL en_b3 got=%h last=%b want BDE38E39 1", out_value, out_last); end
        in_level = 4'd5;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_value !== 32'h3DE38E39 || out_last !== 1'b0) begin errors++;
            $display("FAIL en_b4 got=%h last=%b want 3DE38E39 0", out_value, out_last); end
    endtask

    task automatic test_reset_midstream;
        do_reset;
        en = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_level = 4'd9;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++;
            $display("FAIL mid_fill_o got valid=%b ready=%b want 1 1", out_valid, in_ready); end
        in_level = 4'd11;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || err_count !== 8'd1) begin errors++;
            $display("FAIL mid_fill_s got ready=%b cnt=%0d want 0 1", in_ready, err_count); end
        checks++; if (out_value !== 32'h3F800000) begin errors++;
            $display("FAIL mid_fill_value got=%h want=3F800000", out_value); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_value !== 32'h0) begin errors++;
            $display("FAIL mid_rst_out got valid=%b val=%h want 0 0", out_valid, out_value); end
        checks++; if (out_last !== 1'b0 || out_err !== 1'b0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL mid_rst_flags got last=%b err=%b cnt=%0d want 0 0 0", out_last,
                     out_err, err_count); end
        checks++; if (in_ready !== 1'b0) begin errors++;
            $display("FAIL mid_rst_ready got=%b want=0", in_ready); end
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_level = 4'd6;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) in_valid = 1'b0;
            checks++; if (out_valid !== 1'b1 || out_value !== 32'h3EAAAAAB
                          || out_last !== (i == 3)) begin errors++;
                $display("FAIL post_rst_beat%0d got valid=%b val=%h last=%b want 1 3EAAAAAB %b",
                         i, out_valid, out_value, out_last, (i == 3)); end
        end
    endtask

    initial begin
        fp_tab = '{
            32'hBF800000, 32'hBF471C72, 32'hBF0E38E4, 32'hBEAAAAAB, 32'hBDE38E39,
            32'h3DE38E39, 32'h3EAAAAAB, 32'h3F0E38E4, 32'h3F471C72, 32'h3F800000,
            32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0
        };
        test_reset;
        test_levels;
        test_illegal;
        test_last;
        test_back_to_back;
        test_enable;
        test_reset_midstream;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
